// File: rtl/div_ctrl_if.sv
// EX-request and divider handshake bundle for div_ctrl.
// slave = div_ctrl side, master = pipeline/divider side.
interface div_ctrl_if #(
   parameter int unsigned WIDTH = 32
);
   logic               req_valid_i;
   logic               req_signed_i;
   logic [WIDTH-1:0]   op1_i;
   logic [WIDTH-1:0]   op2_i;
   logic               flush_i;
   logic               stall_o;
   logic               hilo_we_o;
   logic [WIDTH-1:0]   hi_o;
   logic [WIDTH-1:0]   lo_o;
   logic               div_start_o;
   logic               div_signed_o;
   logic [WIDTH-1:0]   div_op1_o;
   logic [WIDTH-1:0]   div_op2_o;
   logic               div_annul_o;
   logic               div_ready_i;
   logic [2*WIDTH-1:0] div_result_i;

   modport slave (
      input  req_valid_i, req_signed_i, op1_i, op2_i, flush_i,
             div_ready_i, div_result_i,
      output stall_o, hilo_we_o, hi_o, lo_o,
             div_start_o, div_signed_o, div_op1_o, div_op2_o, div_annul_o
   );

   modport master (
      output req_valid_i, req_signed_i, op1_i, op2_i, flush_i,
             div_ready_i, div_result_i,
      input  stall_o, hilo_we_o, hi_o, lo_o,
             div_start_o, div_signed_o, div_op1_o, div_op2_o, div_annul_o
   );
endinterface

// File: rtl/div_ctrl.sv
// EX-stage sequencer for the shared multi-cycle divider: start/annul handshake, stall, HI/LO write.
// Optional one-entry result cache enabled by `define DIV_RESULT_CACHE_EN.
module div_ctrl #(
   parameter int unsigned WIDTH        = 32,
   parameter int unsigned ABORT_CYCLES = 3
) (
   input logic      clk,
   input logic      rst,
   div_ctrl_if.slave bus
);

   localparam int unsigned CW = $clog2(ABORT_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE,
      BUSY,
      WRITE,
      DRAIN,
      ABORT
`ifdef DIV_RESULT_CACHE_EN
      , HIT
`endif
   } state_t;

   state_t           state, state_nx;
   logic             sgn_q;
   logic [WIDTH-1:0] op1_q, op2_q;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic [CW-1:0]    abort_cnt;

   logic stall, hilo_we, start, annul;
   logic accept, load_div, load_hit;

`ifdef DIV_RESULT_CACHE_EN
   logic             c_valid;
   logic             c_sgn;
   logic [WIDTH-1:0] c_op1, c_op2;
   logic [WIDTH-1:0] c_hi, c_lo;
   logic             cache_hit;

   assign cache_hit = c_valid && (c_sgn == bus.req_signed_i) &&
                      (c_op1 == bus.op1_i) && (c_op2 == bus.op2_i);
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      stall    = 1'b0;
      hilo_we  = 1'b0;
      start    = 1'b0;
      annul    = 1'b0;
      accept   = 1'b0;
      load_div = 1'b0;
      load_hit = 1'b0;
      case (state)
         IDLE: begin
            if (bus.req_valid_i && !bus.flush_i) begin
               stall    = 1'b1;
               accept   = 1'b1;
               state_nx = BUSY;
`ifdef DIV_RESULT_CACHE_EN
               if (cache_hit) begin
                  load_hit = 1'b1;
                  state_nx = HIT;
               end
`endif
            end
         end
         BUSY: begin
            stall = 1'b1;
            // Flush wins over a same-cycle ready: the result is dropped.
            if (bus.flush_i) begin
               state_nx = ABORT;
            end else begin
               start = 1'b1;
               if (bus.div_ready_i) begin
                  load_div = 1'b1;
                  state_nx = WRITE;
               end
            end
         end
         WRITE: begin
            hilo_we  = 1'b1;
            state_nx = DRAIN;
         end
`ifdef DIV_RESULT_CACHE_EN
         HIT: begin
            hilo_we  = 1'b1;
            state_nx = DRAIN;
         end
`endif
         DRAIN: begin
            stall    = bus.req_valid_i;
            state_nx = IDLE;
         end
         ABORT: begin
            annul = 1'b1;
            if (abort_cnt == CW'(ABORT_CYCLES - 1)) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sgn_q     <= 1'b0;
         op1_q     <= '0;
         op2_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         abort_cnt <= '0;
      end else begin
         if (accept) begin
            sgn_q <= bus.req_signed_i;
            op1_q <= bus.op1_i;
            op2_q <= bus.op2_i;
         end
         if (load_div) begin
            hi_q <= bus.div_result_i[2*WIDTH-1:WIDTH];
            lo_q <= bus.div_result_i[WIDTH-1:0];
         end
`ifdef DIV_RESULT_CACHE_EN
         else if (load_hit) begin
            hi_q <= c_hi;
            lo_q <= c_lo;
         end
`endif
         if (state == ABORT) abort_cnt <= abort_cnt + 1'b1;
         else                abort_cnt <= '0;
      end
   end

`ifdef DIV_RESULT_CACHE_EN
   // Filled from the just-registered HI/LO, so only completed divides land here.
   always_ff @(posedge clk) begin
      if (rst) begin
         c_valid <= 1'b0;
         c_sgn   <= 1'b0;
         c_op1   <= '0;
         c_op2   <= '0;
         c_hi    <= '0;
         c_lo    <= '0;
      end else if (state == WRITE) begin
         c_valid <= 1'b1;
         c_sgn   <= sgn_q;
         c_op1   <= op1_q;
         c_op2   <= op2_q;
         c_hi    <= hi_q;
         c_lo    <= lo_q;
      end
   end
`else
   logic unused_hit;
   assign unused_hit = load_hit;
`endif

   assign bus.stall_o      = stall;
   assign bus.hilo_we_o    = hilo_we;
   assign bus.hi_o         = hi_q;
   assign bus.lo_o         = lo_q;
   assign bus.div_start_o  = start;
   assign bus.div_signed_o = sgn_q;
   assign bus.div_op1_o    = op1_q;
   assign bus.div_op2_o    = op2_q;
   assign bus.div_annul_o  = annul;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a behavioural 32-step divider (35-cycle ready, 3 for divide-by-zero).
module tb_div_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   div_ctrl_if #(.WIDTH(32)) bus ();

   div_ctrl #(.WIDTH(32), .ABORT_CYCLES(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Divider model: ready after a run of consecutive start cycles.
   int unsigned m_cnt;
   int unsigned m_lat;
   logic signed [31:0] sa, sb;

   always_ff @(posedge clk) begin
      if (rst || !bus.div_start_o) m_cnt <= 0;
      else                         m_cnt <= m_cnt + 1;
   end

   always_comb begin
      m_lat = (bus.div_op2_o == '0) ? 2 : 34;
      sa    = bus.div_op1_o;
      sb    = bus.div_op2_o;
      bus.div_ready_i = (m_cnt == m_lat);
      if (bus.div_op2_o == '0)
         bus.div_result_i = '0;
      else if (bus.div_signed_o)
         bus.div_result_i = {32'(sa % sb), 32'(sa / sb)};
      else
         bus.div_result_i = {bus.div_op1_o % bus.div_op2_o, bus.div_op1_o / bus.div_op2_o};
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                          output int stall_n, output int we_at, output int we_n,
                          output int start_n, output logic start_we, output logic [31:0] op1_busy);
      bus.req_valid_i  = 1'b1;
      bus.req_signed_i = sg;
      bus.op1_i        = a;
      bus.op2_i        = b;
      stall_n = 0; we_at = -1; we_n = 0; start_n = 0; start_we = 1'b1; op1_busy = '0;
      for (int unsigned c = 0; c < 60; c++) begin
         if (c == 3 && bus.stall_o) bus.op1_i = ~a;
         #2;
         if (bus.stall_o)     stall_n++;
         if (bus.div_start_o) start_n++;
         if (bus.hilo_we_o) begin
            we_n++;
            if (we_at < 0) begin
               we_at    = int'(c);
               start_we = bus.div_start_o;
            end
         end
         if (c == 5) op1_busy = bus.div_op1_o;
         tick();
         if (we_at >= 0) bus.req_valid_i = 1'b0;
         if (we_at >= 0 && int'(c) >= we_at + 3) break;
      end
      bus.req_valid_i = 1'b0;
   endtask

   task automatic run_flush(input logic [31:0] a, input logic [31:0] b, input int unsigned flush_at,
                            output int annul_n, output int we_n, output logic start_fl,
                            output int stall_ab);
      bus.req_valid_i  = 1'b1;
      bus.req_signed_i = 1'b0;
      bus.op1_i        = a;
      bus.op2_i        = b;
      annul_n = 0; we_n = 0; start_fl = 1'b1; stall_ab = 0;
      for (int unsigned c = 0; c < flush_at + 8; c++) begin
         if (c == flush_at) begin
            bus.flush_i     = 1'b1;
            bus.req_valid_i = 1'b0;
         end
         #2;
         if (c == flush_at) start_fl = bus.div_start_o;
         if (bus.div_annul_o) annul_n++;
         if (bus.hilo_we_o)   we_n++;
         if (c > flush_at && bus.stall_o) stall_ab++;
         tick();
         bus.flush_i = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int stall_n, we_at, we_n, start_n, annul_n, stall_ab;
      logic start_we, start_fl;
      logic [31:0] op1_busy;

      bus.req_valid_i  = 1'b0;
      bus.req_signed_i = 1'b0;
      bus.op1_i        = '0;
      bus.op2_i        = '0;
      bus.flush_i      = 1'b0;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      #2;
      check("rst_stall",  bus.stall_o, 0);
      check("rst_we",     bus.hilo_we_o, 0);
      check("rst_start",  bus.div_start_o, 0);
      check("rst_annul",  bus.div_annul_o, 0);
      check("rst_hi",     bus.hi_o, 0);
      check("rst_lo",     bus.lo_o, 0);
      check("rst_op1",    bus.div_op1_o, 0);
      check("rst_signed", bus.div_signed_o, 0);
      tick();

      // DIVU 100/7
      run_div(1'b0, 32'd100, 32'd7, stall_n, we_at, we_n, start_n, start_we, op1_busy);
      check("divu_stall_cycles", stall_n, 36);
      check("divu_we_cycle",     we_at, 36);
      check("divu_we_pulses",    we_n, 1);
      check("divu_start_in_wr",  start_we, 0);
      check("divu_op1_latched",  op1_busy, 100);
      check("divu_hi",           bus.hi_o, 2);
      check("divu_lo",           bus.lo_o, 14);
      tick(); tick();

      // DIVU 5/0
      run_div(1'b0, 32'd5, 32'd0, stall_n, we_at, we_n, start_n, start_we, op1_busy);
      check("dz_we_cycle", we_at, 4);
      check("dz_we_pulses", we_n, 1);
      check("dz_hi", bus.hi_o, 0);
      check("dz_lo", bus.lo_o, 0);
      check("dz_idle_stall", bus.stall_o, 0);
      tick(); tick();

      // DIV -7/2
      run_div(1'b1, 32'hFFFF_FFF9, 32'd2, stall_n, we_at, we_n, start_n, start_we, op1_busy);
      check("div_we_cycle", we_at, 36);
      check("div_hi", bus.hi_o, 32'hFFFF_FFFF);
      check("div_lo", bus.lo_o, 32'hFFFF_FFFD);
      tick(); tick();

      // Flush while idle: request ignored
      bus.req_valid_i = 1'b1; bus.op1_i = 32'd50; bus.op2_i = 32'd5; bus.flush_i = 1'b1;
      #2;
      check("idle_flush_stall", bus.stall_o, 0);
      tick();
      bus.req_valid_i = 1'b0; bus.flush_i = 1'b0;
      #2;
      check("idle_flush_start", bus.div_start_o, 0);
      tick(); tick();

      // Flush at BUSY cycle 10
      run_flush(32'd200, 32'd3, 10, annul_n, we_n, start_fl, stall_ab);
      check("fl10_start", start_fl, 0);
      check("fl10_annul_cycles", annul_n, 3);
      check("fl10_no_we", we_n, 0);
      check("fl10_stall", stall_ab, 0);
      check("fl10_hi_kept", bus.hi_o, 32'hFFFF_FFFF);
      check("fl10_lo_kept", bus.lo_o, 32'hFFFF_FFFD);

      run_div(1'b0, 32'd9, 32'd3, stall_n, we_at, we_n, start_n, start_we, op1_busy);
      check("post_abort_lo", bus.lo_o, 3);
      check("post_abort_hi", bus.hi_o, 0);
      tick(); tick();

      // Flush in the same cycle as divider ready
      run_flush(32'd77, 32'd5, 35, annul_n, we_n, start_fl, stall_ab);
      check("flrdy_no_we", we_n, 0);
      check("flrdy_annul_cycles", annul_n, 3);
      check("flrdy_lo_kept", bus.lo_o, 3);

      // Reset at BUSY cycle 5
      bus.req_valid_i = 1'b1; bus.req_signed_i = 1'b1; bus.op1_i = 32'd100; bus.op2_i = 32'd7;
      for (int unsigned c = 0; c < 5; c++) tick();
      rst = 1'b1; bus.req_valid_i = 1'b0;
      tick();
      #2;
      check("mrst_stall",  bus.stall_o, 0);
      check("mrst_start",  bus.div_start_o, 0);
      check("mrst_we",     bus.hilo_we_o, 0);
      check("mrst_lo",     bus.lo_o, 0);
      check("mrst_op1",    bus.div_op1_o, 0);
      check("mrst_signed", bus.div_signed_o, 0);
      rst = 1'b0;
      tick(); tick();

      // Repeat of an identical DIVU: cache hit when the feature is built in
      run_div(1'b0, 32'd100, 32'd7, stall_n, we_at, we_n, start_n, start_we, op1_busy);
      check("rep1_we_cycle", we_at, 36);
      tick(); tick();
      run_div(1'b0, 32'd100, 32'd7, stall_n, we_at, we_n, start_n, start_we, op1_busy);
`ifdef DIV_RESULT_CACHE_EN
      check("rep2_we_cycle", we_at, 1);
      check("rep2_start_cycles", start_n, 0);
`else
      check("rep2_we_cycle", we_at, 36);
      check("rep2_start_cycles", start_n, 35);
`endif
      check("rep2_hi", bus.hi_o, 2);
      check("rep2_lo", bus.lo_o, 14);
      tick(); tick();

      run_div(1'b0, 32'd100, 32'd8, stall_n, we_at, we_n, start_n, start_we, op1_busy);
      check("miss_we_cycle", we_at, 36);
      check("miss_hi", bus.hi_o, 4);
      check("miss_lo", bus.lo_o, 12);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
